// File: rtl/n2_ic_fill_asm_if.sv
// Return-beat and fill-write bundle between the L2 return path, the fill
// assembler and the fetch-control arbiter / I-cache data array.
interface n2_ic_fill_asm_if #(
  parameter int BEATS   = 4,
  parameter int INSTR_W = 32,
  parameter int IDX_W   = 6
);
  localparam int LINE_W = 2 * BEATS * (INSTR_W + 1);

  logic                   beat_vld;
  logic [2*INSTR_W-1:0]   beat_data;
  logic                   beat_err;
  logic [IDX_W-1:0]       beat_index;
  logic [2:0]             beat_way;
  logic                   beat_rdy;
  logic                   fill_abort;
  logic                   fill_wr_req;
  logic                   fill_wr_ack;
  logic [LINE_W-1:0]      cmu_ic_data;
  logic [IDX_W-1:0]       fill_index;
  logic [2:0]             fill_wrway;
  logic                   fill_err;
  logic                   fill_par_inj;

  // Return path and arbiter side
  modport master (
    output beat_vld, beat_data, beat_err, beat_index, beat_way,
           fill_abort, fill_wr_ack, fill_par_inj,
    input  beat_rdy, fill_wr_req, cmu_ic_data, fill_index, fill_wrway, fill_err
  );

  // Assembler side
  modport slave (
    input  beat_vld, beat_data, beat_err, beat_index, beat_way,
           fill_abort, fill_wr_ack, fill_par_inj,
    output beat_rdy, fill_wr_req, cmu_ic_data, fill_index, fill_wrway, fill_err
  );
endinterface

// File: rtl/n2_ic_fill_asm.sv
// I-cache fill assembler: packs BEATS two-instruction L2 beats into one parity-protected line
// and holds it as a write request. Optional slot-0 parity inject: N2_IC_FILL_PAR_INJ_EN.
module n2_ic_fill_asm #(
  parameter int BEATS   = 4,
  parameter int INSTR_W = 32,
  parameter int IDX_W   = 6
) (
  input  logic              l2clk,
  input  logic              rst_l,
  n2_ic_fill_asm_if.slave   fill_if
);
  localparam int SLOT_W = INSTR_W + 1;
  localparam int SLOTS  = 2 * BEATS;
  localparam int CNT_W  = $clog2(BEATS);

  typedef enum logic [1:0] {IDLE, ACCUM, REQ} state_t;

  state_t              state_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                beat_rdy_reg;
  logic                fill_wr_req_reg;
  logic                fill_err_reg;
  logic [IDX_W-1:0]    fill_index_reg;
  logic [2:0]          fill_wrway_reg;
  logic [SLOT_W-1:0]   slot_reg [SLOTS];
  logic [SLOT_W-1:0]   beat_slot [2];
  logic                xfer;
  logic                inj_bit;

  assign xfer = fill_if.beat_vld && beat_rdy_reg;

`ifdef N2_IC_FILL_PAR_INJ_EN
  assign inj_bit = fill_if.fill_par_inj;
`else
  logic unused_par_inj;
  assign unused_par_inj = fill_if.fill_par_inj;
  assign inj_bit        = 1'b0;
`endif

  // Even parity per instruction, computed as the beat arrives
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_beat_slot
      assign beat_slot[gi] = {^fill_if.beat_data[gi*INSTR_W +: INSTR_W],
                              fill_if.beat_data[gi*INSTR_W +: INSTR_W]};
    end
    for (gi = 0; gi < SLOTS; gi++) begin : g_line_out
      assign fill_if.cmu_ic_data[gi*SLOT_W +: SLOT_W] = slot_reg[gi];
    end
  endgenerate

  assign fill_if.beat_rdy    = beat_rdy_reg;
  assign fill_if.fill_wr_req = fill_wr_req_reg;
  assign fill_if.fill_err    = fill_err_reg;
  assign fill_if.fill_index  = fill_index_reg;
  assign fill_if.fill_wrway  = fill_wrway_reg;

  always_ff @(posedge l2clk or negedge rst_l) begin
    if (!rst_l) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      beat_rdy_reg    <= 1'b1;
      fill_wr_req_reg <= 1'b0;
      fill_err_reg    <= 1'b0;
      fill_index_reg  <= '0;
      fill_wrway_reg  <= '0;
      for (int i = 0; i < SLOTS; i++) slot_reg[i] <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (xfer) begin
            fill_index_reg <= fill_if.beat_index;
            fill_wrway_reg <= fill_if.beat_way;
            slot_reg[0]    <= {beat_slot[0][INSTR_W] ^ inj_bit, beat_slot[0][INSTR_W-1:0]};
            slot_reg[1]    <= beat_slot[1];
            fill_err_reg   <= fill_if.beat_err;
            cnt_reg        <= CNT_W'(1);
            state_reg      <= ACCUM;
          end
        end
        ACCUM: begin
          // Abort takes priority over a beat presented in the same cycle
          if (fill_if.fill_abort) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            fill_err_reg <= 1'b0;
          end else if (xfer) begin
            slot_reg[{cnt_reg, 1'b0}] <= beat_slot[0];
            slot_reg[{cnt_reg, 1'b1}] <= beat_slot[1];
            fill_err_reg <= fill_err_reg | fill_if.beat_err;
            if (cnt_reg == CNT_W'(BEATS - 1)) begin
              state_reg       <= REQ;
              cnt_reg         <= '0;
              beat_rdy_reg    <= 1'b0;
              fill_wr_req_reg <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
        end
        REQ: begin
          if (fill_if.fill_wr_ack) begin
            state_reg       <= IDLE;
            beat_rdy_reg    <= 1'b1;
            fill_wr_req_reg <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_n2_ic_fill_asm.sv
// Self-checking bench for n2_ic_fill_asm: directed scenarios plus randomized lines
// checked against a line-level reference model.
module tb_n2_ic_fill_asm;
`ifdef N2_IC_FILL_PAR_INJ_EN
  localparam bit INJ_EN = 1'b1;
`else
  localparam bit INJ_EN = 1'b0;
`endif

  logic l2clk = 1'b0;
  logic rst_l = 1'b1;
  int   checks = 0;
  int   failures = 0;

  n2_ic_fill_asm_if #(.BEATS(4), .INSTR_W(32), .IDX_W(6)) fif ();
  n2_ic_fill_asm #(.BEATS(4), .INSTR_W(32), .IDX_W(6)) dut (
    .l2clk  (l2clk),
    .rst_l  (rst_l),
    .fill_if(fif)
  );

  always #5 l2clk = ~l2clk;

  // Reference model of the line expected at the request
  logic [63:0] exp_beats [4];
  logic [5:0]  exp_idx;
  logic [2:0]  exp_way;
  logic        exp_err;
  logic        exp_inj;

  function automatic logic [263:0] model_line();
    logic [263:0] line;
    logic [31:0]  w;
    line = '0;
    for (int i = 0; i < 8; i++) begin
      w = exp_beats[i/2][(i%2)*32 +: 32];
      line[33*i +: 33] = {^w, w};
    end
    if (INJ_EN && exp_inj) line[32] = ~line[32];
    return line;
  endfunction

  task automatic step();
    @(posedge l2clk);
    #1;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic err, input logic [5:0] idx,
                           input logic [2:0] way, input logic inj);
    int n;
    n = 0;
    fif.beat_vld = 1'b1; fif.beat_data = d; fif.beat_err = err;
    fif.beat_index = idx; fif.beat_way = way; fif.fill_par_inj = inj;
    while (fif.beat_rdy !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL beat_rdy_timeout: beat_rdy=%b required 1 within 50 cycles", fif.beat_rdy);
    end
    step();
    fif.beat_vld = 1'b0; fif.beat_err = 1'b0; fif.fill_par_inj = 1'b0;
    fif.beat_data = {$urandom, $urandom};
  endtask

  task automatic check_no_req(input string tag);
    checks++;
    if (fif.fill_wr_req !== 1'b0) begin
      failures++;
      $display("FAIL %s_no_req: fill_wr_req=%b required 0", tag, fif.fill_wr_req);
    end
  endtask

  task automatic check_line(input string tag);
    logic [263:0] line;
    line = model_line();
    checks++;
    if (fif.fill_wr_req !== 1'b1 || fif.beat_rdy !== 1'b0) begin
      failures++;
      $display("FAIL %s_req: req=%b rdy=%b required req=1 rdy=0", tag, fif.fill_wr_req, fif.beat_rdy);
    end
    checks++;
    if (fif.cmu_ic_data !== line) begin
      failures++;
      $display("FAIL %s_data: got %h required %h", tag, fif.cmu_ic_data, line);
    end
    checks++;
    if (fif.fill_index !== exp_idx || fif.fill_wrway !== exp_way || fif.fill_err !== exp_err) begin
      failures++;
      $display("FAIL %s_meta: idx=%h way=%0d err=%b required idx=%h way=%0d err=%b", tag,
               fif.fill_index, fif.fill_wrway, fif.fill_err, exp_idx, exp_way, exp_err);
    end
    $display("line %s idx=%h way=%0d err=%b req=%b", tag, fif.fill_index, fif.fill_wrway,
             fif.fill_err, fif.fill_wr_req);
  endtask

  // Full line of four beats; random idle gaps carry stray acks that must be ignored
  task automatic run_line(input string tag, input logic [63:0] d0, input logic [63:0] d1,
                          input logic [63:0] d2, input logic [63:0] d3, input logic [5:0] idx,
                          input logic [2:0] way, input logic [3:0] errs, input logic inj,
                          input int gap_max);
    logic [63:0] d [4];
    int gap;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    for (int k = 0; k < 4; k++) exp_beats[k] = d[k];
    exp_idx = idx; exp_way = way; exp_err = |errs; exp_inj = inj;
    for (int k = 0; k < 4; k++) begin
      gap = (gap_max > 0) ? int'($urandom_range(gap_max)) : 0;
      for (int g = 0; g < gap; g++) begin
        fif.fill_wr_ack = 1'($urandom);
        step();
      end
      fif.fill_wr_ack = 1'b0;
      // index/way change on later beats must not be captured
      send_beat(d[k], errs[k], (k == 0) ? idx : 6'($urandom), (k == 0) ? way : 3'($urandom),
                (k == 0) ? inj : 1'($urandom));
      if (k < 3) check_no_req(tag);
      else check_line(tag);
    end
  endtask

  task automatic ack_line(input string tag);
    fif.fill_wr_ack = 1'b1;
    step();
    fif.fill_wr_ack = 1'b0;
    checks++;
    if (fif.fill_wr_req !== 1'b0 || fif.beat_rdy !== 1'b1) begin
      failures++;
      $display("FAIL %s_ack: req=%b rdy=%b required req=0 rdy=1", tag, fif.fill_wr_req, fif.beat_rdy);
    end
  endtask

  task automatic abort_after(input string tag, input int k);
    for (int j = 0; j < k; j++) begin
      send_beat({$urandom, $urandom}, 1'b1, 6'($urandom), 3'($urandom), 1'b0);
      check_no_req(tag);
    end
    fif.beat_vld = 1'b1; fif.fill_abort = 1'b1; fif.beat_data = {$urandom, $urandom};
    step();
    fif.beat_vld = 1'b0; fif.fill_abort = 1'b0;
    checks++;
    if (fif.fill_wr_req !== 1'b0 || fif.beat_rdy !== 1'b1 || fif.fill_err !== 1'b0) begin
      failures++;
      $display("FAIL %s_abort: req=%b rdy=%b err=%b required 0 1 0", tag, fif.fill_wr_req,
               fif.beat_rdy, fif.fill_err);
    end
  endtask

  task automatic test_reset();
    #2 rst_l = 1'b0;
    #3;
    checks++;
    if (fif.cmu_ic_data !== '0 || fif.fill_index !== '0 || fif.fill_wrway !== '0 ||
        fif.fill_err !== 1'b0 || fif.fill_wr_req !== 1'b0 || fif.beat_rdy !== 1'b1) begin
      failures++;
      $display("FAIL reset_state: data=%h idx=%h way=%0d err=%b req=%b rdy=%b", fif.cmu_ic_data,
               fif.fill_index, fif.fill_wrway, fif.fill_err, fif.fill_wr_req, fif.beat_rdy);
    end
    @(negedge l2clk);
    rst_l = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [7:0] par;
    run_line("basic", 64'h00000001_00000000, 64'h00000003_00000002, 64'h00000005_00000004,
             64'h00000007_00000006, 6'h2A, 3'd5, 4'b0000, 1'b0, 0);
    for (int i = 0; i < 8; i++) par[i] = fif.cmu_ic_data[33*i+32];
    checks++;
    if (par !== 8'b1001_0110) begin
      failures++;
      $display("FAIL basic_parity: got %b required 10010110", par);
    end
    ack_line("basic");
  endtask

  task automatic test_hold();
    logic [63:0] x;
    logic [263:0] line;
    run_line("hold_a", {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
             {$urandom, $urandom}, 6'h11, 3'd2, 4'b0000, 1'b0, 1);
    line = model_line();
    x = {$urandom, $urandom};
    fif.beat_vld = 1'b1; fif.beat_data = x; fif.beat_index = 6'h33; fif.beat_way = 3'd6;
    fif.fill_abort = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (fif.fill_wr_req !== 1'b1 || fif.beat_rdy !== 1'b0 || fif.cmu_ic_data !== line ||
          fif.fill_index !== 6'h11 || fif.fill_wrway !== 3'd2) begin
        failures++;
        $display("FAIL hold_stable: cycle %0d req=%b rdy=%b idx=%h way=%0d", c, fif.fill_wr_req,
                 fif.beat_rdy, fif.fill_index, fif.fill_wrway);
      end
    end
    fif.fill_abort = 1'b0;
    ack_line("hold");
    run_line("hold_b", x, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
             6'h33, 3'd6, 4'b0000, 1'b0, 0);
    ack_line("hold_b");
  endtask

  task automatic test_err();
    run_line("err", {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
             {$urandom, $urandom}, 6'h05, 3'd1, 4'b0010, 1'b0, 1);
    ack_line("err");
    run_line("err_clean", {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
             {$urandom, $urandom}, 6'h06, 3'd3, 4'b0000, 1'b0, 1);
    ack_line("err_clean");
  endtask

  task automatic test_abort();
    abort_after("abort", 2);
    run_line("abort_next", {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
             {$urandom, $urandom}, 6'h3C, 3'd7, 4'b0000, 1'b0, 0);
    ack_line("abort_next");
  endtask

  task automatic test_async_reset();
    send_beat(64'hDEADBEEF_CAFEF00D, 1'b1, 6'h2F, 3'd4, 1'b0);
    send_beat(64'h12345678_9ABCDEF0, 1'b0, 6'h00, 3'd0, 1'b0);
    #2 rst_l = 1'b0;
    #1;
    checks++;
    if (fif.cmu_ic_data !== '0 || fif.fill_index !== '0 || fif.fill_wrway !== '0 ||
        fif.fill_err !== 1'b0 || fif.fill_wr_req !== 1'b0 || fif.beat_rdy !== 1'b1) begin
      failures++;
      $display("FAIL async_reset: data=%h idx=%h way=%0d err=%b req=%b rdy=%b", fif.cmu_ic_data,
               fif.fill_index, fif.fill_wrway, fif.fill_err, fif.fill_wr_req, fif.beat_rdy);
    end
    @(negedge l2clk);
    rst_l = 1'b1;
    step();
    run_line("post_reset", {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
             {$urandom, $urandom}, 6'h15, 3'd2, 4'b0000, 1'b0, 0);
    ack_line("post_reset");
  endtask

  task automatic test_par_inj();
    run_line("par_inj", 64'h0, 64'h0, 64'h0, 64'h0, 6'h01, 3'd0, 4'b0000, 1'b1, 0);
    checks++;
    if (fif.cmu_ic_data[32] !== INJ_EN) begin
      failures++;
      $display("FAIL par_inj_bit: slot0 parity=%b required %b", fif.cmu_ic_data[32], INJ_EN);
    end
    ack_line("par_inj");
  endtask

  task automatic test_random();
    int wait_req;
    for (int n = 0; n < 20; n++) begin
      if ($urandom_range(3) == 0) abort_after("rnd", int'($urandom_range(3, 1)));
      run_line("rnd", {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
               {$urandom, $urandom}, 6'($urandom), 3'($urandom), 4'($urandom_range(15) & 
               (($urandom_range(1) == 0) ? 32'hF : 32'h0)), 1'($urandom), 2);
      wait_req = int'($urandom_range(3));
      for (int c = 0; c < wait_req; c++) begin
        fif.fill_abort = 1'($urandom);
        step();
        fif.fill_abort = 1'b0;
        check_line("rnd_hold");
      end
      ack_line("rnd");
    end
  endtask

  initial begin
    fif.beat_vld = 1'b0; fif.beat_data = '0; fif.beat_err = 1'b0; fif.beat_index = '0;
    fif.beat_way = '0; fif.fill_abort = 1'b0; fif.fill_wr_ack = 1'b0; fif.fill_par_inj = 1'b0;
    test_reset();
    test_basic();
    test_hold();
    test_err();
    test_abort();
    test_async_reset();
    test_par_inj();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
